// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: func3 size codes, MEM FSM states and lane width shared by the MEM stage
package mem_access_stage_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int LANE_W = 8;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align_ext: shifts the read word to the addressed lane and sign/zero-extends it by func3
//   rdata  in  32  read data word from memory
//   a      in  2   byte offset of the access
//   func3  in  3   access size/sign code
//   result out 32  write-back value (word loads and undefined codes pass rdata through)
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  func3,
    output logic [31:0] result
);
    logic [31:0] sh;
    assign sh = rdata >> (LANE_W * a);
    assign result = func3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                    func3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                    func3 == F3_BU ? {24'b0, sh[7:0]} :
                    func3 == F3_HU ? {16'b0, sh[15:0]} : rdata;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 MEM stage with req/gnt/rvalid data-memory handshake, store lanes and load alignment
//   clk, rst (async active-low)
//   alu_out, rs2_data, rd_index, dm_w_en, wb_sel, wb_en, func3, halt : registered E/M inputs
//   dm_req, dm_we, dm_addr, dm_wdata, dm_be / dm_gnt, dm_rvalid, dm_rdata : data-memory bus
//   mem_stall : freezes IF..EX while the current op cannot retire this edge
//   mw_wb_data, mw_rd_index, mw_wb_en, mw_halt : M/W register
//   misalign_err, bus_err : one-cycle error pulses aligned with the M/W bubble they cause
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_index,
    input  logic [3:0]  dm_w_en,
    input  logic        wb_sel,
    input  logic        wb_en,
    input  logic [2:0]  func3,
    input  logic        halt,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic [31:0] mw_wb_data,
    output logic [4:0]  mw_rd_index,
    output logic        mw_wb_en,
    output logic        mw_halt,
    output logic        misalign_err,
    output logic        bus_err
);
    state_t st, nxt;
    logic [7:0] cnt;
    logic is_store, is_load, mem_op, is_b, is_h, misal, tmo;
    logic [3:0] be;
    logic [31:0] wdata, ld_data;
    assign is_store = |dm_w_en;
    assign is_load  = wb_sel & wb_en & ~is_store;
    assign mem_op   = is_store | is_load;
    assign is_b     = func3 == F3_B || func3 == F3_BU;
    assign is_h     = func3 == F3_H || func3 == F3_HU;
    assign misal    = mem_op & (is_h ? alu_out[0] : ~is_b & |alu_out[1:0]);
    assign be       = is_b ? 4'b0001 << alu_out[1:0] : is_h ? 4'b0011 << alu_out[1:0] : 4'hF;
    assign wdata    = is_b ? {24'b0, rs2_data[7:0]} << (LANE_W * alu_out[1:0]) :
                      is_h ? {16'b0, rs2_data[15:0]} << (LANE_W * alu_out[1:0]) : rs2_data;
    // Timeout only fires when the handshake makes no progress in this cycle.
    assign tmo      = st != IDLE && cnt == 8'(TIMEOUT_CYC - 1) &&
                      !(st == REQ && dm_gnt) && !(st == RESP && dm_rvalid);
    assign dm_req   = (st == IDLE && mem_op && !misal) || st == REQ;
    assign dm_we    = dm_req & is_store;
    assign dm_addr  = dm_req ? {alu_out[31:2], 2'b00} : 32'b0;
    assign dm_be    = dm_req ? be : 4'b0;
    assign dm_wdata = dm_req ? wdata : 32'b0;
    load_align_ext u_align (
        .rdata  (dm_rdata),
        .a      (alu_out[1:0]),
        .func3  (func3),
        .result (ld_data)
    );
    always_comb begin
        nxt = st;
        mem_stall = 1'b0;
        case (st)
            IDLE, REQ: if (dm_req) begin
                nxt = dm_gnt ? (is_load ? RESP : IDLE) : REQ;
                mem_stall = is_load | ~dm_gnt;
            end
            RESP: begin
                nxt = dm_rvalid ? IDLE : RESP;
                mem_stall = ~dm_rvalid;
            end
            default: nxt = IDLE;
        endcase
        if (tmo) begin
            nxt = IDLE;
            mem_stall = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= IDLE;
            cnt <= 8'd0;
        end else begin
            st  <= nxt;
            cnt <= nxt != st ? 8'd0 : st != IDLE ? cnt + 8'd1 : cnt;
        end
    end
    // Stall cycles insert a full bubble; data/rd are held so only the enables matter downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_wb_data   <= 32'b0;
            mw_rd_index  <= 5'b0;
            mw_wb_en     <= 1'b0;
            mw_halt      <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= misal;
            bus_err      <= tmo;
            if (mem_stall) begin
                mw_wb_en <= 1'b0;
                mw_halt  <= 1'b0;
            end else begin
                mw_wb_en    <= wb_en & ~misal & ~tmo;
                mw_halt     <= halt;
                mw_rd_index <= rd_index;
                mw_wb_data  <= is_load ? ld_data : alu_out;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors with a retire-event scoreboard checked by an independent monitor
module tb_mem_access_stage;
    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] alu_out, rs2_data, dm_rdata, dm_addr, dm_wdata, mw_wb_data;
    logic [4:0] rd_index, mw_rd_index;
    logic [3:0] dm_w_en, dm_be;
    logic [2:0] func3;
    logic wb_sel, wb_en, halt, dm_req, dm_we, dm_gnt, dm_rvalid, mem_stall;
    logic mw_wb_en, mw_halt, misalign_err, bus_err;
    int total = 0, bad = 0;
    typedef struct packed {logic [3:0] ev; logic [4:0] rd; logic [31:0] data;} ev_t;
    ev_t q[$];
    // ev bits: [3] bus_err, [2] misalign_err, [1] mw_wb_en, [0] mw_halt
    localparam logic [3:0] EV_WB = 4'b0010, EV_MIS = 4'b0100, EV_MISH = 4'b0101, EV_BUS = 4'b1000;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .alu_out(alu_out), .rs2_data(rs2_data), .rd_index(rd_index),
        .dm_w_en(dm_w_en), .wb_sel(wb_sel), .wb_en(wb_en), .func3(func3), .halt(halt),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
        .mw_wb_data(mw_wb_data), .mw_rd_index(mw_rd_index), .mw_wb_en(mw_wb_en), .mw_halt(mw_halt),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_nop();
        alu_out = 0; rs2_data = 0; rd_index = 0; dm_w_en = 0;
        wb_sel = 0; wb_en = 0; func3 = 0; halt = 0;
    endtask

    // Called at a negedge; returns at the negedge following the retire edge.
    task automatic run_op(input string nm, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [3:0] wen, input logic wsel,
                          input logic wben, input logic [2:0] f3, input logic hlt,
                          input int gdly, input int rdly, input logic [31:0] rdat,
                          input int x_stall, input int x_req, input logic [31:0] x_addr,
                          input logic [3:0] x_be, input logic [31:0] x_wd,
                          input logic [3:0] x_ev, input logic [31:0] x_data);
        int g, r, ns, nr;
        logic granted, stl;
        g = 0; r = 0; ns = 0; nr = 0; granted = 0; stl = 0;
        if (x_ev != 0) q.push_back('{x_ev, rd, x_data});
        alu_out = alu; rs2_data = rs2; rd_index = rd; dm_w_en = wen;
        wb_sel = wsel; wb_en = wben; func3 = f3; halt = hlt;
        for (int c = 0; c < 400; c++) begin
            dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
            if (granted) begin
                if (r == rdly) begin dm_rvalid = 1; dm_rdata = rdat; end
                r++;
            end
            #1;
            if (dm_req) nr++;
            if (dm_req && !granted) begin
                if (g == gdly) begin
                    dm_gnt = 1; granted = 1;
                    chk({nm, "_addr"}, dm_addr, x_addr);
                    chk({nm, "_be"}, {28'b0, dm_be}, {28'b0, x_be});
                    chk({nm, "_wdata"}, dm_wdata, x_wd);
                    chk({nm, "_we"}, {31'b0, dm_we}, {31'b0, |wen});
                end else g++;
            end
            #1;
            stl = mem_stall;
            if (stl) ns++;
            @(negedge clk);
            if (!stl) break;
        end
        dm_gnt = 0; dm_rvalid = 0;
        chk({nm, "_stall_cycles"}, ns, x_stall);
        chk({nm, "_req_cycles"}, nr, x_req);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (mw_wb_en | misalign_err | bus_err | mw_halt) begin
                if (q.size() == 0) chk("unexpected_event", {28'b0, bus_err, misalign_err, mw_wb_en, mw_halt}, 0);
                else begin
                    e = q.pop_front();
                    chk("event_flags", {28'b0, bus_err, misalign_err, mw_wb_en, mw_halt}, {28'b0, e.ev});
                    if (e.ev[1]) begin
                        chk("wb_rd", {27'b0, mw_rd_index}, {27'b0, e.rd});
                        chk("wb_data", mw_wb_data, e.data);
                    end
                end
            end
        end
    end

    initial begin : stim
        set_nop();
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {dm_req, dm_we, mem_stall, mw_wb_en, mw_halt, misalign_err, bus_err}, 0);
        chk("rst_wb_data", mw_wb_data, 0);
        chk("rst_rd_index", {27'b0, mw_rd_index}, 0);
        rst = 1;
        //     name     alu          rs2          rd wen    sel en f3      h gd   rd rdat         stall req addr         be       wdata        ev       data
        run_op("alu",   32'h1234,    0,           5, 4'h0,  0, 1, 3'b000, 0, 0,   0, 0,           0,   0,  0,           4'h0,    0,           EV_WB,   32'h1234);
        run_op("sb",    32'h103,     32'hAB,      0, 4'h1,  0, 0, 3'b000, 0, 0,   0, 0,           0,   1,  32'h100,     4'b1000, 32'hAB000000, 4'h0,   0);
        run_op("lb",    32'h2,       0,           7, 4'h0,  1, 1, 3'b000, 0, 0,   0, 32'h00800000, 1,  1,  32'h0,       4'b0100, 0,           EV_WB,   32'hFFFFFF80);
        run_op("lbu",   32'h2,       0,           8, 4'h0,  1, 1, 3'b100, 0, 0,   0, 32'h00800000, 1,  1,  32'h0,       4'b0100, 0,           EV_WB,   32'h00000080);
        run_op("lw",    32'h40,      0,           9, 4'h0,  1, 1, 3'b010, 0, 3,   1, 32'hDEADBEEF, 5,  4,  32'h40,      4'hF,    0,           EV_WB,   32'hDEADBEEF);
        run_op("lh_mis",32'h1,       0,           10,4'h0,  1, 1, 3'b001, 1, 0,   0, 0,           0,   0,  0,           4'h0,    0,           EV_MISH, 0);
        run_op("sw_mis",32'h6,       32'h55,      0, 4'hF,  0, 0, 3'b010, 0, 0,   0, 0,           0,   0,  0,           4'h0,    0,           EV_MIS,  0);
        run_op("lh",    32'h22,      0,           11,4'h0,  1, 1, 3'b001, 0, 0,   0, 32'h80010000, 1,  1,  32'h20,      4'b1100, 0,           EV_WB,   32'hFFFF8001);
        run_op("lhu",   32'h22,      0,           12,4'h0,  1, 1, 3'b101, 0, 0,   0, 32'h80010000, 1,  1,  32'h20,      4'b1100, 0,           EV_WB,   32'h00008001);
        run_op("sh",    32'h32,      32'h12345678,0, 4'h3,  0, 0, 3'b001, 0, 0,   0, 0,           0,   1,  32'h30,      4'b1100, 32'h56780000, 4'h0,   0);
        run_op("sw",    32'h48,      32'hCAFEF00D,0, 4'hF,  0, 0, 3'b010, 0, 2,   0, 0,           2,   3,  32'h48,      4'hF,    32'hCAFEF00D, 4'h0,   0);
        run_op("lw_tmo",32'h80,      0,           13,4'h0,  1, 1, 3'b010, 0, 1000,0, 0,           255, 256,0,           4'h0,    0,           EV_BUS,  0);
        run_op("alu2",  32'h55AA,    0,           3, 4'h0,  0, 1, 3'b000, 0, 0,   0, 0,           0,   0,  0,           4'h0,    0,           EV_WB,   32'h55AA);
        // Reset while a load waits in RESP; late rvalid afterwards must be ignored.
        alu_out = 32'h10; rd_index = 6; wb_sel = 1; wb_en = 1; func3 = 3'b010;
        dm_gnt = 1;
        @(negedge clk);
        dm_gnt = 0;
        set_nop();
        rst = 0;
        #1;
        chk("rst_resp_wb_data", mw_wb_data, 0);
        chk("rst_resp_flags", {dm_req, mem_stall, mw_wb_en, mw_halt, bus_err}, 0);
        @(negedge clk);
        rst = 1;
        q.push_back('{EV_WB, 5'd4, 32'h77});
        alu_out = 32'h77; rd_index = 4; wb_en = 1;
        dm_rvalid = 1; dm_rdata = 32'hFFFFFFFF;
        #1;
        chk("late_rvalid_stall", {31'b0, mem_stall}, 0);
        @(negedge clk);
        dm_rvalid = 0;
        set_nop();
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
